// File: rtl/uart_tx_feeder_if.sv
// Host write port and UART launch port of the transmit feeder.
// master drives bytes and tx_done; slave is the feeder itself.
interface uart_tx_feeder_if #(
  parameter int ADDR_W = 4
);
  logic            wr_en;
  logic [7:0]      wr_data;
  logic            full;
  logic            empty;
  logic [ADDR_W:0] level;
  logic            overflow;
  logic            tx_start;
  logic [7:0]      tx_data;
  logic            tx_done;
  logic            busy;

  modport master (
    output wr_en, wr_data, tx_done,
    input  full, empty, level, overflow,
    input  tx_start, tx_data, busy
  );

  modport slave (
    input  wr_en, wr_data, tx_done,
    output full, empty, level, overflow,
    output tx_start, tx_data, busy
  );
endinterface

// File: rtl/uart_tx_feeder.sv
// Byte FIFO plus launch sequencer feeding a UART transmitter,
// one byte per frame with a guard gap after each txdone.
module uart_tx_feeder #(
  parameter int DEPTH      = 16,
  parameter int ADDR_W     = 4,
  parameter int GAP_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  uart_tx_feeder_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    BUSY,
    GAP
  } state_t;

  localparam int GW =
    (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LD =
    (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;
  localparam logic [ADDR_W:0] FULL_LVL =
    (ADDR_W+1)'(DEPTH);

  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   level;
  logic [ADDR_W:0]   level_n;
  logic              full;
  logic              empty;
  logic              overflow;
  logic              tx_start;
  logic [7:0]        tx_data;
  logic [7:0]        data_n;
  state_t            state;
  state_t            state_n;
  logic [GW-1:0]     gap;
  logic [GW-1:0]     gap_n;
  logic              push;
  logic              pop;

  // full is the pre-edge value, so a pop on the same edge
  // never makes room for a write.
  assign push = bus.wr_en & ~full;

  always_comb begin
    state_n = state;
    gap_n   = gap;
    data_n  = tx_data;
    pop     = 1'b0;
    unique case (state)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          data_n  = mem[rd_ptr];
          state_n = LOAD;
        end
      end
      LOAD: state_n = BUSY;
      BUSY: begin
        if (bus.tx_done) begin
          if (GAP_CYCLES == 0) begin
            state_n = IDLE;
          end else begin
            gap_n   = GAP_LD;
            state_n = GAP;
          end
        end
      end
      GAP: begin
        if (gap == '0) state_n = IDLE;
        else           gap_n   = gap - 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    level_n = level;
    unique case ({push, pop})
      2'b10:   level_n = level + 1'b1;
      2'b01:   level_n = level - 1'b1;
      default: level_n = level;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      gap      <= '0;
      tx_start <= 1'b0;
      tx_data  <= 8'h00;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      overflow <= 1'b0;
    end else begin
      state    <= state_n;
      gap      <= gap_n;
      tx_start <= (state_n == LOAD);
      tx_data  <= data_n;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      level    <= level_n;
      full     <= (level_n == FULL_LVL);
      empty    <= (level_n == '0);
      overflow <= bus.wr_en & full;
    end
  end

  assign bus.full     = full;
  assign bus.empty    = empty;
  assign bus.level    = level;
  assign bus.overflow = overflow;
  assign bus.tx_start = tx_start;
  assign bus.tx_data  = tx_data;
  assign bus.busy     = (state != IDLE);

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Randomised bench for uart_tx_feeder against a
// queue-based frame/gap timing model.
module tb_uart_tx_feeder;

  localparam int G  = 4;
  localparam int DP = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;

  uart_tx_feeder_if #(.ADDR_W(4)) bus ();

  uart_tx_feeder #(
    .DEPTH(DP),
    .ADDR_W(4),
    .GAP_CYCLES(G)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  // model: queue of buffered bytes plus frame timing
  logic [7:0] q[$];
  logic [7:0] m_data;
  bit m_start, m_ovf, m_busy, in_frame;
  int k, launch_edge, gap_end;
  int done_cnt, delay;
  bit hold, stray;

  task automatic model_reset();
    q.delete();
    m_data   = 8'h00;
    m_start  = 0;
    m_ovf    = 0;
    m_busy   = 0;
    in_frame = 0;
    k        = 0;
    gap_end  = 0;
    launch_edge = 0;
    done_cnt = 0;
  endtask

  task automatic model_edge(
    input bit we, input logic [7:0] wd, input bit td
  );
    bit launch;
    int cnt;
    k++;
    cnt    = q.size();
    launch = !m_busy && cnt > 0;
    m_ovf  = we && cnt == DP;
    // txdone counts only once the launch cycle is over
    if (in_frame && td && k >= launch_edge + 2) begin
      in_frame = 0;
      gap_end  = k + G;
    end
    if (launch) begin
      m_data      = q.pop_front();
      in_frame    = 1;
      launch_edge = k;
    end
    if (we && cnt < DP) q.push_back(wd);
    m_start = launch;
    m_busy  = in_frame || k < gap_end;
  endtask

  task automatic compare_all();
    check("level", 32'(bus.level), 32'(q.size()));
    check("empty", 32'(bus.empty), 32'(q.size() == 0));
    check("full", 32'(bus.full), 32'(q.size() == DP));
    check("overflow", 32'(bus.overflow), 32'(m_ovf));
    check("tx_start", 32'(bus.tx_start), 32'(m_start));
    check("tx_data", 32'(bus.tx_data), 32'(m_data));
    check("busy", 32'(bus.busy), 32'(m_busy));
  endtask

  task automatic cycle(
    input bit we, input logic [7:0] wd, input bit tdf
  );
    bit td;
    td = tdf || (!hold && done_cnt == 1) ||
         (stray && $urandom_range(0, 15) == 0);
    bus.wr_en   = we;
    bus.wr_data = wd;
    bus.tx_done = td;
    @(posedge clk);
    model_edge(we, wd, td);
    if (m_start)       done_cnt = delay;
    else if (!in_frame) done_cnt = 0;
    else if (done_cnt > 0) done_cnt--;
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    int rate;
    bus.wr_en   = 0;
    bus.wr_data = 8'h00;
    bus.tx_done = 0;
    hold  = 0;
    stray = 0;
    delay = 20;
    model_reset();
    repeat (2) @(negedge clk);
    compare_all();
    rst = 0;

    // single byte
    cycle(1, 8'hA5, 0);
    check("t1_level", 32'(bus.level), 32'd1);
    cycle(0, 8'h00, 0);
    check("t1_start", 32'(bus.tx_start), 32'd1);
    check("t1_data", 32'(bus.tx_data), 32'hA5);
    repeat (40) cycle(0, 8'h00, 0);

    // burst of five
    for (int i = 1; i <= 5; i++) cycle(1, 8'(i), 0);
    repeat (160) cycle(0, 8'h00, 0);

    // fill with txdone withheld
    hold = 1;
    for (int i = 0; i < 18; i++) cycle(1, 8'(8'h40 + i), 0);
    check("t3_full", 32'(bus.full), 32'd1);
    check("t3_ovf", 32'(bus.overflow), 32'd1);
    check("t3_level", 32'(bus.level), 32'd16);

    // write on the very edge the sequencer pops
    cycle(0, 8'h00, 1);
    repeat (G) cycle(0, 8'h00, 0);
    cycle(1, 8'hEE, 0);
    check("t4_ovf", 32'(bus.overflow), 32'd1);
    check("t4_level", 32'(bus.level), 32'd15);
    check("t4_start", 32'(bus.tx_start), 32'd1);
    hold  = 0;
    delay = 6;
    repeat (300) cycle(0, 8'h00, 0);

    // stray txdone in idle and gap
    repeat (3) cycle(0, 8'h00, 1);
    cycle(1, 8'h77, 0);
    repeat (12) cycle(0, 8'h00, 1);
    repeat (5) cycle(0, 8'h00, 0);

    // reset mid-frame with bytes buffered
    hold = 1;
    for (int i = 0; i < 4; i++) cycle(1, 8'(8'hC0 + i), 0);
    check("t6_pre_level", 32'(bus.level), 32'd3);
    #2 rst = 1;
    #1;
    check("t6_start", 32'(bus.tx_start), 32'd0);
    check("t6_data", 32'(bus.tx_data), 32'h00);
    check("t6_empty", 32'(bus.empty), 32'd1);
    check("t6_busy", 32'(bus.busy), 32'd0);
    check("t6_level", 32'(bus.level), 32'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst  = 0;
    hold = 0;
    repeat (10) cycle(0, 8'h00, 0);

    // random traffic with stray txdone
    stray = 1;
    rate  = 50;
    for (int n = 0; n < 3000; n++) begin
      if (n % 500 == 0) rate = $urandom_range(5, 95);
      delay = $urandom_range(2, 25);
      cycle($urandom_range(0, 99) < rate,
            8'($urandom), 0);
    end
    stray = 0;
    delay = 4;
    repeat (600) cycle(0, 8'h00, 0);
    check("drain_empty", 32'(bus.empty), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
